// File: rtl/ddr2_wr_data_fifo.sv
// DDR2 write-data FIFO and DQ/DQS burst sequencer.
// Define DDR2_WR_MASK_EN to store byte masks per entry and drive them on DM.
module ddr2_wr_data_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int WR_LAT     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_fifo_push,
    input  logic [DATA_WIDTH-1:0]   wr_data_rise_in,
    input  logic [DATA_WIDTH-1:0]   wr_data_fall_in,
    input  logic [DATA_WIDTH/8-1:0] wr_mask_rise_in,
    input  logic [DATA_WIDTH/8-1:0] wr_mask_fall_in,
    input  logic                    wr_cmd,
    output logic                    wr_fifo_full,
    output logic [4:0]              wr_fifo_count,
    output logic [DATA_WIDTH-1:0]   write_data_rise,
    output logic [DATA_WIDTH-1:0]   write_data_fall,
    output logic [DATA_WIDTH/8-1:0] write_mask_rise,
    output logic [DATA_WIDTH/8-1:0] write_mask_fall,
    output logic                    write_en,
    output logic                    dqs_en,
    output logic                    dqs_rst,
    output logic                    wr_busy,
    output logic                    wr_overflow,
    output logic                    wr_underrun,
    output logic                    wr_cmd_err
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int NB = BURST_LEN / 2;
`ifdef DDR2_WR_MASK_EN
    localparam int EW = 2 * DATA_WIDTH + 2 * MW;
`else
    localparam int EW = 2 * DATA_WIDTH;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t        state;
    logic [3:0]    lat_cnt;
    logic [1:0]    beat_cnt;
    logic [3:0]    wr_ptr;
    logic [3:0]    rd_ptr;
    logic [EW-1:0] mem [16];
    logic [EW-1:0] entry;
    logic [EW-1:0] rd_entry;
    logic          pop;
    logic          push_ok;
    logic          pop_ok;
    logic          pop_empty;

    // A beat leaves the FIFO on every edge that enters a DATA cycle.
    assign pop       = (state == S_PRE) ||
                       (state == S_DATA && beat_cnt != 2'd0);
    assign push_ok   = wr_fifo_push && !wr_fifo_full;
    assign pop_ok    = pop && (wr_fifo_count != 5'd0);
    assign pop_empty = pop && (wr_fifo_count == 5'd0);
    assign wr_fifo_full = (wr_fifo_count == 5'd16);
    assign wr_busy   = (state != S_IDLE);
    assign rd_entry  = mem[rd_ptr];

`ifdef DDR2_WR_MASK_EN
    assign entry = {wr_data_rise_in, wr_data_fall_in,
                    wr_mask_rise_in, wr_mask_fall_in};
`else
    logic unused_mask;
    assign unused_mask = ^{wr_mask_rise_in, wr_mask_fall_in};
    assign entry = {wr_data_rise_in, wr_data_fall_in};
    assign write_mask_rise = '0;
    assign write_mask_fall = '0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            wr_fifo_count   <= '0;
            wr_overflow     <= 1'b0;
            wr_underrun     <= 1'b0;
            write_data_rise <= '0;
            write_data_fall <= '0;
`ifdef DDR2_WR_MASK_EN
            write_mask_rise <= '0;
            write_mask_fall <= '0;
`endif
        end else begin
            wr_fifo_count <= wr_fifo_count + 5'(push_ok) - 5'(pop_ok);
            if (wr_fifo_push && wr_fifo_full) begin
                wr_overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop_ok) begin
                rd_ptr          <= rd_ptr + 4'd1;
                write_data_rise <= rd_entry[EW-1 -: DATA_WIDTH];
                write_data_fall <= rd_entry[EW-DATA_WIDTH-1 -: DATA_WIDTH];
`ifdef DDR2_WR_MASK_EN
                write_mask_rise <= rd_entry[2*MW-1 -: MW];
                write_mask_fall <= rd_entry[MW-1:0];
`endif
            end else if (pop_empty) begin
                wr_underrun     <= 1'b1;
                write_data_rise <= '0;
                write_data_fall <= '0;
`ifdef DDR2_WR_MASK_EN
                write_mask_rise <= '1;
                write_mask_fall <= '1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            beat_cnt   <= '0;
            write_en   <= 1'b0;
            dqs_en     <= 1'b0;
            dqs_rst    <= 1'b0;
            wr_cmd_err <= 1'b0;
        end else begin
            if (wr_cmd && state != S_IDLE) begin
                wr_cmd_err <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (wr_cmd) begin
                        if (WR_LAT == 2) begin
                            state   <= S_PRE;
                            dqs_en  <= 1'b1;
                            dqs_rst <= 1'b1;
                        end else begin
                            state   <= S_WAIT;
                            lat_cnt <= 4'(WR_LAT - 2);
                        end
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state   <= S_PRE;
                        dqs_en  <= 1'b1;
                        dqs_rst <= 1'b1;
                    end
                end
                S_PRE: begin
                    state    <= S_DATA;
                    beat_cnt <= 2'(NB - 1);
                    dqs_rst  <= 1'b0;
                    write_en <= 1'b1;
                end
                S_DATA: begin
                    if (beat_cnt == 2'd0) begin
                        state    <= S_POST;
                        write_en <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt - 2'd1;
                    end
                end
                S_POST: begin
                    state  <= S_IDLE;
                    dqs_en <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
